// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths and operand tag extraction constants
package core_pkg;
  localparam int ROBID_W = 7;
  localparam int OP_W    = 5;
  localparam int RD_W    = 6;
  localparam int XLEN    = 32;
  // A not-ready operand carries its producer ROB id in these bits
  localparam int TAG_LSB = 0;
  localparam int TAG_MSB = ROBID_W - 1;
endpackage

// File: rtl/exers_sched_if.sv
// rtl/exers_sched_if.sv - dispatch, writeback broadcast and issue signals of the scheduler
interface exers_sched_if;
  import core_pkg::*;

  logic                rename_exers_write;
  logic [OP_W-1:0]     rename_op;
  logic [ROBID_W-1:0]  rename_robid;
  logic [RD_W-1:0]     rename_rd;
  logic                rename_op1ready;
  logic [XLEN-1:0]     rename_op1;
  logic                rename_op2ready;
  logic [XLEN-1:0]     rename_op2;
  logic [XLEN-1:0]     rename_imm;
  logic                exers_stall;
  logic                wb_valid;
  logic [ROBID_W-1:0]  wb_robid;
  logic [XLEN-1:0]     wb_value;
  logic                issue_valid;
  logic [OP_W-1:0]     issue_op;
  logic [ROBID_W-1:0]  issue_robid;
  logic [RD_W-1:0]     issue_rd;
  logic [XLEN-1:0]     issue_op1;
  logic [XLEN-1:0]     issue_op2;
  logic [XLEN-1:0]     issue_imm;
  logic                alu_stall;
  logic                rob_flush;

  modport master (
    output rename_exers_write, rename_op, rename_robid, rename_rd,
           rename_op1ready, rename_op1, rename_op2ready, rename_op2, rename_imm,
           wb_valid, wb_robid, wb_value, alu_stall, rob_flush,
    input  exers_stall, issue_valid, issue_op, issue_robid, issue_rd,
           issue_op1, issue_op2, issue_imm
  );

  modport slave (
    input  rename_exers_write, rename_op, rename_robid, rename_rd,
           rename_op1ready, rename_op1, rename_op2ready, rename_op2, rename_imm,
           wb_valid, wb_robid, wb_value, alu_stall, rob_flush,
    output exers_stall, issue_valid, issue_op, issue_robid, issue_rd,
           issue_op1, issue_op2, issue_imm
  );
endinterface

// File: rtl/exers_age_select.sv
// rtl/exers_age_select.sv - age matrix with oldest-ready one-hot select
module exers_age_select #(
  parameter int DEPTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic             clr_en,
  input  logic [IDXW-1:0]  clr_idx,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] ready,
  output logic             sel_valid,
  output logic [DEPTH-1:0] sel_onehot,
  output logic [IDXW-1:0]  sel_idx
);
  // age[i][j] = 1 : entry i is older than entry j
  logic [DEPTH-1:0][DEPTH-1:0] age;
  logic [DEPTH-1:0]            older;

  always_ff @(posedge clk) begin
    if (rst) begin
      age <= '0;
    end else begin
      if (wr_en) begin
        for (int j = 0; j < DEPTH; j++) begin
          age[wr_idx][j] <= 1'b0;
          age[j][wr_idx] <= (j != int'(wr_idx)) && valid[j];
        end
      end
      // Stale rows/columns of dead entries are masked by ready, but clear them anyway
      if (clr_en) begin
        for (int j = 0; j < DEPTH; j++) begin
          age[clr_idx][j] <= 1'b0;
          age[j][clr_idx] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    sel_idx    = '0;
    older      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) older[j] = age[j][i];
      sel_onehot[i] = ready[i] & ~|(older & ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_onehot[i]) sel_idx = IDXW'(i);
    end
  end

  assign sel_valid = |sel_onehot;
endmodule

// File: rtl/exers_sched.sv
// rtl/exers_sched.sv - reservation station payloads, CDB wakeup and registered issue stage
module exers_sched
  import core_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDXW  = 3
) (
  input  logic         clk,
  input  logic         rst,
  exers_sched_if.slave bus
);
  logic [DEPTH-1:0]   valid, valid_nxt, rdy1, rdy2, ready, sel_onehot;
  logic [OP_W-1:0]    op_q    [DEPTH];
  logic [ROBID_W-1:0] robid_q [DEPTH];
  logic [RD_W-1:0]    rd_q    [DEPTH];
  logic [XLEN-1:0]    val1_q  [DEPTH];
  logic [XLEN-1:0]    val2_q  [DEPTH];
  logic [XLEN-1:0]    imm_q   [DEPTH];
  logic [IDXW-1:0]    wr_idx, sel_idx;
  logic               full, wr_en, sel_valid, adv, iss_en, in1_hit, in2_hit;

  logic               iss_valid;
  logic [OP_W-1:0]    iss_op;
  logic [ROBID_W-1:0] iss_robid;
  logic [RD_W-1:0]    iss_rd;
  logic [XLEN-1:0]    iss_op1, iss_op2, iss_imm;

  // Full is judged on registered valid only; an issue this cycle does not admit a write
  assign full    = &valid;
  assign ready   = valid & rdy1 & rdy2;
  assign adv     = ~iss_valid | ~bus.alu_stall;
  assign iss_en  = adv & sel_valid & ~bus.rob_flush;
  assign wr_en   = bus.rename_exers_write & ~full & ~bus.rob_flush;
  assign in1_hit = ~bus.rename_op1ready & bus.wb_valid &
                   (bus.rename_op1[TAG_MSB:TAG_LSB] == bus.wb_robid);
  assign in2_hit = ~bus.rename_op2ready & bus.wb_valid &
                   (bus.rename_op2[TAG_MSB:TAG_LSB] == bus.wb_robid);

  always_comb begin
    wr_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) wr_idx = IDXW'(i);
    end
  end

  always_comb begin
    valid_nxt = valid;
    if (iss_en) valid_nxt = valid_nxt & ~sel_onehot;
    if (wr_en)  valid_nxt[wr_idx] = 1'b1;
  end

  exers_age_select #(.DEPTH(DEPTH), .IDXW(IDXW)) u_age (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .clr_en     (iss_en),
    .clr_idx    (sel_idx),
    .valid      (valid),
    .ready      (ready),
    .sel_valid  (sel_valid),
    .sel_onehot (sel_onehot),
    .sel_idx    (sel_idx)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.rob_flush) begin
      valid     <= '0;
      iss_valid <= 1'b0;
    end else begin
      valid <= valid_nxt;
      if (adv) iss_valid <= sel_valid;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && bus.wb_valid) begin
        if (!rdy1[i] && val1_q[i][TAG_MSB:TAG_LSB] == bus.wb_robid) begin
          rdy1[i]   <= 1'b1;
          val1_q[i] <= bus.wb_value;
        end
        if (!rdy2[i] && val2_q[i][TAG_MSB:TAG_LSB] == bus.wb_robid) begin
          rdy2[i]   <= 1'b1;
          val2_q[i] <= bus.wb_value;
        end
      end
    end
    if (wr_en) begin
      op_q[wr_idx]    <= bus.rename_op;
      robid_q[wr_idx] <= bus.rename_robid;
      rd_q[wr_idx]    <= bus.rename_rd;
      imm_q[wr_idx]   <= bus.rename_imm;
      rdy1[wr_idx]    <= bus.rename_op1ready | in1_hit;
      rdy2[wr_idx]    <= bus.rename_op2ready | in2_hit;
      val1_q[wr_idx]  <= in1_hit ? bus.wb_value : bus.rename_op1;
      val2_q[wr_idx]  <= in2_hit ? bus.wb_value : bus.rename_op2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_op    <= '0;
      iss_robid <= '0;
      iss_rd    <= '0;
      iss_op1   <= '0;
      iss_op2   <= '0;
      iss_imm   <= '0;
    end else if (iss_en) begin
      iss_op    <= op_q[sel_idx];
      iss_robid <= robid_q[sel_idx];
      iss_rd    <= rd_q[sel_idx];
      iss_op1   <= val1_q[sel_idx];
      iss_op2   <= val2_q[sel_idx];
      iss_imm   <= imm_q[sel_idx];
    end
  end

  assign bus.exers_stall = full;
  assign bus.issue_valid = iss_valid;
  assign bus.issue_op    = iss_op;
  assign bus.issue_robid = iss_robid;
  assign bus.issue_rd    = iss_rd;
  assign bus.issue_op1   = iss_op1;
  assign bus.issue_op2   = iss_op2;
  assign bus.issue_imm   = iss_imm;
endmodule

// File: tb/tb_exers_sched.sv
// tb/tb_exers_sched.sv - self-checking bench for exers_sched with an age-ordered queue model
module tb_exers_sched;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   check_en = 1'b0;

  exers_sched_if bus ();

  exers_sched #(.DEPTH(8), .IDXW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [6:0]  robid;
    logic [5:0]  rd;
    bit          r1;
    bit          r2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
  } ent_t;

  // Model: entries kept oldest-first in a queue
  ent_t q[$];
  bit   m_iv = 1'b0;
  ent_t m_is;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ent_t ne;
    int   sel;
    bit   adv;
    bit   accept;
    if (rst || bus.rob_flush) begin
      q.delete();
      m_iv = 1'b0;
    end else begin
      adv    = !m_iv || !bus.alu_stall;
      accept = bus.rename_exers_write && (q.size() < 8);
      sel    = -1;
      foreach (q[i]) if (sel < 0 && q[i].r1 && q[i].r2) sel = i;
      ne.op = bus.rename_op; ne.robid = bus.rename_robid; ne.rd = bus.rename_rd;
      ne.imm = bus.rename_imm;
      ne.r1 = bus.rename_op1ready; ne.v1 = bus.rename_op1;
      ne.r2 = bus.rename_op2ready; ne.v2 = bus.rename_op2;
      if (bus.wb_valid) begin
        if (!ne.r1 && ne.v1[6:0] == bus.wb_robid) begin ne.r1 = 1; ne.v1 = bus.wb_value; end
        if (!ne.r2 && ne.v2[6:0] == bus.wb_robid) begin ne.r2 = 1; ne.v2 = bus.wb_value; end
        foreach (q[i]) begin
          if (!q[i].r1 && q[i].v1[6:0] == bus.wb_robid) begin q[i].r1 = 1; q[i].v1 = bus.wb_value; end
          if (!q[i].r2 && q[i].v2[6:0] == bus.wb_robid) begin q[i].r2 = 1; q[i].v2 = bus.wb_value; end
        end
      end
      if (adv) begin
        if (sel >= 0) begin
          m_is = q[sel];
          q.delete(sel);
          m_iv = 1'b1;
        end else begin
          m_iv = 1'b0;
        end
      end
      if (accept) q.push_back(ne);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("issue_valid", {31'b0, bus.issue_valid}, {31'b0, m_iv});
      chk("exers_stall", {31'b0, bus.exers_stall}, {31'b0, q.size() == 8});
      if (m_iv) begin
        chk("issue_op",    {27'b0, bus.issue_op},    {27'b0, m_is.op});
        chk("issue_robid", {25'b0, bus.issue_robid}, {25'b0, m_is.robid});
        chk("issue_rd",    {26'b0, bus.issue_rd},    {26'b0, m_is.rd});
        chk("issue_op1",   bus.issue_op1, m_is.v1);
        chk("issue_op2",   bus.issue_op2, m_is.v2);
        chk("issue_imm",   bus.issue_imm, m_is.imm);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rename_exers_write = 1'b0;
    bus.wb_valid           = 1'b0;
    bus.rob_flush          = 1'b0;
  endtask

  task automatic wr(input logic [6:0] robid, input bit r1, input logic [31:0] o1,
                    input bit r2, input logic [31:0] o2);
    bus.rename_exers_write = 1'b1;
    bus.rename_op          = robid[4:0];
    bus.rename_robid       = robid;
    bus.rename_rd          = {1'b0, robid[4:0]};
    bus.rename_op1ready    = r1;
    bus.rename_op1         = o1;
    bus.rename_op2ready    = r2;
    bus.rename_op2         = o2;
    bus.rename_imm         = 32'h1000 + {25'b0, robid};
  endtask

  task automatic wb(input logic [6:0] robid, input logic [31:0] value);
    bus.wb_valid = 1'b1;
    bus.wb_robid = robid;
    bus.wb_value = value;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wr(7'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    bus.rename_exers_write = 1'b0;
    bus.wb_robid = '0; bus.wb_value = '0; bus.alu_stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_en = 1'b1;
    chk("rst_issue_valid", {31'b0, bus.issue_valid}, 32'd0);
    chk("rst_stall", {31'b0, bus.exers_stall}, 32'd0);
    chk("rst_issue_op1", bus.issue_op1, 32'd0);

    // Both operands ready at write: issue one edge later
    wr(7'h01, 1'b1, 32'd5, 1'b1, 32'd7);
    tick(); idle();
    chk("t1_not_yet", {31'b0, bus.issue_valid}, 32'd0);
    tick();
    chk("t1_valid", {31'b0, bus.issue_valid}, 32'd1);
    chk("t1_op1", bus.issue_op1, 32'd5);
    chk("t1_op2", bus.issue_op2, 32'd7);
    tick();

    // Tag wakeup, then write-time bypass
    wr(7'h02, 1'b0, 32'h12, 1'b1, 32'd9);
    tick(); idle();
    wb(7'h12, 32'hDEAD);
    tick(); idle();
    chk("t2_wait", {31'b0, bus.issue_valid}, 32'd0);
    tick();
    chk("t2_op1", bus.issue_op1, 32'hDEAD);
    wr(7'h03, 1'b0, 32'h13, 1'b1, 32'd4);
    wb(7'h13, 32'hBEEF);
    tick(); idle();
    tick();
    chk("t2_byp_robid", {25'b0, bus.issue_robid}, 32'd3);
    chk("t2_byp_op1", bus.issue_op1, 32'hBEEF);
    tick();

    // Age order: 3 and 5 share a producer tag, 4 waits on another
    wr(7'h03, 1'b0, 32'h30, 1'b1, 32'd1); tick();
    wr(7'h04, 1'b0, 32'h31, 1'b1, 32'd2); tick();
    wr(7'h05, 1'b0, 32'h30, 1'b1, 32'd3); tick(); idle();
    wb(7'h30, 32'hAAAA); tick(); idle();
    tick();
    chk("t3_first", {25'b0, bus.issue_robid}, 32'd3);
    tick();
    chk("t3_second", {25'b0, bus.issue_robid}, 32'd5);
    tick();
    chk("t3_held", {31'b0, bus.issue_valid}, 32'd0);
    wb(7'h31, 32'hBBBB); tick(); idle();
    tick();
    chk("t3_last", {25'b0, bus.issue_robid}, 32'd4);
    tick();

    // Fill to full; 9th write dropped
    for (int i = 0; i < 8; i++) begin
      wr(7'h40 + 7'(i), 1'b0, 32'h50 + i, 1'b1, 32'h0);
      tick();
    end
    chk("t4_full", {31'b0, bus.exers_stall}, 32'd1);
    wr(7'h7F, 1'b1, 32'd1, 1'b1, 32'd1);
    tick(); idle();
    chk("t4_still_full", {31'b0, bus.exers_stall}, 32'd1);
    wb(7'h53, 32'h5353); tick(); idle();
    chk("t4_full_after_wake", {31'b0, bus.exers_stall}, 32'd1);
    tick();
    chk("t4_issue", {25'b0, bus.issue_robid}, 32'h43);
    chk("t4_stall_drop", {31'b0, bus.exers_stall}, 32'd0);

    // Hold under alu_stall
    wb(7'h50, 32'h5050); tick();
    wb(7'h51, 32'h5151); tick(); idle();
    bus.alu_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold", {25'b0, bus.issue_robid}, 32'h40);
    end
    bus.alu_stall = 1'b0;
    tick();
    chk("t5_release", {25'b0, bus.issue_robid}, 32'h41);

    // Flush with 5 entries valid and issue register occupied
    wb(7'h52, 32'h5252);
    wr(7'h60, 1'b0, 32'h70, 1'b1, 32'h0);
    tick(); idle();
    tick();
    chk("t6_pre_valid", {31'b0, bus.issue_valid}, 32'd1);
    chk("t6_pre_robid", {25'b0, bus.issue_robid}, 32'h42);
    bus.rob_flush = 1'b1;
    wr(7'h61, 1'b1, 32'd1, 1'b1, 32'd2);
    tick(); idle();
    chk("t6_flushed", {31'b0, bus.issue_valid}, 32'd0);
    tick();
    chk("t6_write_dropped", {31'b0, bus.issue_valid}, 32'd0);
    wb(7'h54, 32'h5454); tick(); idle();
    tick();
    chk("t6_no_revive", {31'b0, bus.issue_valid}, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exers_sched.md
Name: exers_sched

Overview:
- Execution reservation station and issue scheduler between rename and the single integer ALU.
- Accepts renamed micro-ops on the rename_exers_write path and holds them until both operands are ready.
- Captures operand values from the writeback (CDB) broadcast.
- Each cycle, issues the oldest ready entry through a registered issue stage to the ALU; back-pressures rename when full.

Parameters:
DEPTH, 8, number of station entries (power of two, 2..16)
IDXW, 3, entry index width, log2(DEPTH)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
rename_exers_write  input  1  dispatch request
rename_op  input  5  ALU op code
rename_robid  input  7  ROB id of the micro-op
rename_rd  input  6  destination (bit5 = no-write)
rename_op1ready  input  1  op1 holds a value (1) or a tag (0)
rename_op1  input  32  value, or ROB tag in bits[6:0]
rename_op2ready  input  1  as op1
rename_op2  input  32  as op1
rename_imm  input  32  immediate
exers_stall  output  1  station full, write not accepted
wb_valid  input  1  writeback broadcast valid
wb_robid  input  7  producing ROB id
wb_value  input  32  produced value
issue_valid  output  1  issue register holds a micro-op
issue_op  output  5  op
issue_robid  output  7  ROB id
issue_rd  output  6  destination
issue_op1  output  32  operand 1 value
issue_op2  output  32  operand 2 value
issue_imm  output  32  immediate
alu_stall  input  1  ALU cannot accept this cycle
rob_flush  input  1  squash all contents

Behaviour:
- Entry state: valid, op, robid, rd, imm, and per operand a rdy bit plus a 32-bit tag/value field.
- exers_stall: combinational, equal to "all DEPTH entries valid". Same-cycle issue does NOT free a slot for a same-cycle write; this is conservative by design.
- Write acceptance:
  - Accepted when rename_exers_write & ~exers_stall & ~rob_flush.
  - Written into the lowest-index invalid entry.
- Write-time bypass: if an incoming operand has rdy=0 and wb_valid & wb_robid == tag[6:0] in the same cycle, store it rdy=1 with wb_value.
- Wakeup:
  - Every edge, each valid entry operand with rdy=0 and a matching tag on wb_valid sets rdy=1 and value=wb_value.
  - Both operands may wake on the same broadcast.
- Age tracking: DEPTH x DEPTH age matrix; age[i][j]=1 means i is older than j.
  - On write to entry k: age[j][k]=valid[j] for all j≠k; age[k][*]=0.
- Select:
  - ready[i] = valid & op1.rdy & op2.rdy, using registered state only (no same-cycle wakeup-to-select path).
  - Selected entry = ready[i] with no ready j such that age[j][i].
  - Exactly one or zero entries selected.
- Issue register advance: adv = ~issue_valid | ~alu_stall.
  - On adv with a selected entry: load the entry into the issue outputs, set issue_valid=1, clear that entry's valid at the same edge.
  - On adv with no selection: issue_valid <= 0.
  - With issue_valid & alu_stall: all issue outputs hold and no entry is removed.
- Latency:
  - An operand-ready write at edge N is presented with issue_valid=1 after edge N+1.
  - A wakeup at edge N gives issue at edge N+1 at earliest.
- Flush/reset:
  - rst or rob_flush clears every entry's valid and issue_valid at the next edge.
  - Writes and wakeups that cycle are discarded.
  - rst also zeroes the age matrix and all issue_* data outputs.
  - After reset: issue_valid=0, exers_stall=0.
- Simultaneous write + issue + wakeup in one cycle are all legal and independent.
  - A write never targets the entry being issued that cycle, because that entry is still valid.

Decomposition:
- Shared package core_pkg: ROBID_W=7, OP_W=5, RD_W=6, XLEN=32, and the tag-extraction constant (tag = bits[6:0]).
- Sub-module exers_age_select: holds the age matrix and implements write-update, oldest-ready select (one-hot plus index), and entry-clear.
- The parent exers_sched holds entry payloads, wakeup, and the issue register.

Test Plan:
- Reset, then write op1=5 ready, op2=7 ready at edge 1 -> issue_valid=1 after edge 2 with issue_op1=5, issue_op2=7; exers_stall=0 throughout.
- Write entry with op1 tag 0x12 not ready, then wb_valid robid=0x12 value=0xDEAD at edge 4 -> issue after edge 5 with issue_op1=0xDEAD. Repeat with wb in the same cycle as the write -> bypass; issue one edge after the write.
- Write ROB 3, 4, 5 all not ready; wake 5, then 3 in the same cycle -> ROB 3 issues first (older), then 5; ROB 4 is held.
- Fill 8 entries with tag-pending ops -> exers_stall=1; a 9th write is not stored; after one wakeup+issue, exers_stall drops in the cycle after the entry leaves.
- Hold alu_stall=1 with issue_valid=1 for 3 cycles -> issue outputs are stable and the station keeps all remaining entries; release -> next oldest issues the following edge.
- rob_flush with 5 entries valid and issue_valid=1 -> all invalid and issue_valid=0 next edge; a write asserted in the flush cycle is dropped.
